// File: rtl/midi_pkg.sv
// midi_pkg: constants and types shared by the MIDI transmitter slice.
//   MIDI_BAUD        nominal MIDI bit rate
//   ST_CHAN_LO       first channel status byte (0x80)
//   ST_SYS_LO        first system common byte (0xF0)
//   ST_RT_LO         first real-time byte (0xF8)
//   tx_state_t       framer state encoding
//   is_chan_status   0x80..0xEF
//   is_sys_common    0xF0..0xF7
package midi_pkg;

    localparam int         MIDI_BAUD  = 31250;
    localparam logic [7:0] ST_CHAN_LO = 8'h80;
    localparam logic [7:0] ST_SYS_LO  = 8'hF0;
    localparam logic [7:0] ST_RT_LO   = 8'hF8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic logic is_chan_status(input logic [7:0] b);
        return (b >= ST_CHAN_LO) && (b < ST_SYS_LO);
    endfunction

    function automatic logic is_sys_common(input logic [7:0] b);
        return (b >= ST_SYS_LO) && (b < ST_RT_LO);
    endfunction

endpackage

// File: rtl/midi_uart_tx_if.sv
// midi_uart_tx_if: byte handshake into the MIDI transmitter.
//   data   byte to send, stable while valid && !ready
//   valid  producer has a byte
//   ready  transmitter can take a byte; transfer on valid && ready
interface midi_uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/midi_baud_gen.sv
// midi_baud_gen: bit-period timer.
//   clk      clock
//   rst      asynchronous active-low reset
//   restart  reload the count so the next tick is DIV cycles away
//   tick     one-cycle pulse every DIV cycles
// DIV must be at least 2.
module midi_baud_gen #(
    parameter int DIV = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (restart || cnt == '0)
            cnt <= CW'(DIV - 1);
        else
            cnt <= cnt - 1'b1;
    end

    // A restart cycle never ticks, so the first tick of a frame lands
    // exactly DIV cycles after the restart edge.
    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/midi_uart_tx.sv
// midi_uart_tx: MIDI 8N1 serial transmitter.
//   clk    clock, all state on the rising edge
//   rst    asynchronous active-low reset
//   bus    byte handshake (data/valid in, ready out)
//   tx     serial line, idle high, driven straight from a flop
//   busy   high while a frame is on the line
// Optional build macro MIDI_TX_RUNNING_STATUS_EN: drop channel status
// bytes that repeat the last transmitted status.
module midi_uart_tx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = MIDI_BAUD
) (
    input  logic                 clk,
    input  logic                 rst,
    midi_uart_tx_if.slave        bus,
    output logic                 tx,
    output logic                 busy
);
    localparam int DIV = CLK_HZ / BAUD;

    tx_state_t  state_q, state_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] bit_q, bit_d;
    logic       tx_q, tx_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       accept, send_ok, start_frame, tick;

    assign accept = bus.valid && ready_q;

    midi_baud_gen #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (start_frame),
        .tick    (tick)
    );

`ifdef MIDI_TX_RUNNING_STATUS_EN
    // Last channel status put on the line; 0 means none (never matches).
    logic [7:0] rs_q, rs_d;

    always_comb begin
        rs_d    = rs_q;
        send_ok = 1'b1;
        if (state_q == IDLE && accept) begin
            if (is_chan_status(bus.data)) begin
                if (bus.data == rs_q)
                    send_ok = 1'b0;
                else
                    rs_d = bus.data;
            end else if (is_sys_common(bus.data)) begin
                rs_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rs_q <= '0;
        else
            rs_q <= rs_d;
    end
`else
    assign send_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // tx_d is the level for the bit period beginning at the next edge, so
    // each transition loads the following bit; sh_q holds the bits not yet sent.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept && send_ok) begin
                    state_d     = START;
                    sh_d        = bus.data;
                    bit_d       = '0;
                    tx_d        = 1'b0;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                end
            end
            DATA: begin
                if (tick) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = sh_q[0];
                        sh_d = {1'b0, sh_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (tick)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign bus.ready = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_midi_uart_tx.sv
`timescale 1ns/1ps
module tb_midi_uart_tx;
    localparam int DIV = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, busy;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] m_rs = 8'h00;

    midi_uart_tx_if bus();

    midi_uart_tx #(.CLK_HZ(1000000), .BAUD(31250)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: does the MIDI line carry a frame for this byte?
    function automatic bit model_sends(input logic [7:0] b);
`ifdef MIDI_TX_RUNNING_STATUS_EN
        if (b >= 8'h80 && b <= 8'hEF) begin
            if (b == m_rs) return 1'b0;
            m_rs = b;
            return 1'b1;
        end
        if (b >= 8'hF0 && b <= 8'hF7) m_rs = 8'h00;
        return 1'b1;
`else
        return (b === b);
`endif
    endfunction

    task automatic wait_ready();
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.ready === 1'b1);
        end
        if (!seen) chk("ready_wait", {31'd0, bus.ready}, 32'd1);
    endtask

    // Present b for one handshake; returns just after the transfer edge.
    task automatic xfer(input logic [7:0] b);
        wait_ready();
        bus.data  = b;
        bus.valid = 1'b1;
        @(posedge clk);
        #1 bus.valid = 1'b0;
    endtask

    // Called right after the transfer edge: expects the 8N1 frame of b,
    // each bit held DIV cycles, then idle with ready back up.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0]  fr;
        logic [31:0] s;
        int nbusy = 0;
        int nrdy  = 0;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                s[c] = tx;
                if (busy !== 1'b1) nbusy++;
                if (bus.ready !== 1'b0) nrdy++;
            end
            chk($sformatf("%s_bit%0d", tag, i), s, {32{fr[i]}});
        end
        chk({tag, "_busy_low"}, nbusy, 0);
        chk({tag, "_ready_high"}, nrdy, 0);
        @(negedge clk);
        chk({tag, "_end_ready"}, {31'd0, bus.ready}, 32'd1);
        chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_end_tx"}, {31'd0, tx}, 32'd1);
    endtask

    task automatic check_dropped(input string tag);
        int bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || bus.ready !== 1'b1) bad++;
        end
        chk({tag, "_dropped"}, bad, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        xfer(b);
        if (model_sends(b)) check_frame(b, tag);
        else check_dropped(tag);
    endtask

    initial begin
        logic [7:0] seq [10];
        logic [7:0] rb;
        int nlow;
        bus.data  = 8'h00;
        bus.valid = 1'b0;

        // reset state
        #3 rst = 1'b0;
        #4;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'd0, bus.ready}, 32'd1);

        // directed byte list, running-status cases included
        seq = '{8'h90, 8'h3C, 8'h7F, 8'h90, 8'h40, 8'h00, 8'hF8, 8'h90, 8'hF0, 8'h90};
        foreach (seq[i]) send_byte(seq[i], $sformatf("seq%0d", i));
        send_byte(8'h90, "rep90");

        // back-to-back with valid held: exactly one idle cycle between frames
        wait_ready();
        bus.data  = 8'h3C;
        bus.valid = 1'b1;
        @(posedge clk);
        #1 bus.data = 8'h7F;
        void'(model_sends(8'h3C));
        check_frame(8'h3C, "b2b0");
        @(posedge clk);
        #1 bus.valid = 1'b0;
        void'(model_sends(8'h7F));
        check_frame(8'h7F, "b2b1");

        // reset mid-frame
        xfer(8'h55);
        repeat (150) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        m_rs = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rel_ready", {31'd0, bus.ready}, 32'd1);
        nlow = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) nlow++;
        end
        chk("midrst_residual", nlow, 0);
        send_byte(8'h90, "post_rst90");

        // randomized bytes biased toward repeated status
        for (int k = 0; k < 14; k++) begin
            case ($urandom_range(0, 3))
                0: rb = 8'h90;
                1: rb = 8'hB3;
                2: rb = 8'($urandom_range(240, 255));
                default: rb = 8'($urandom);
            endcase
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_byte(rb, $sformatf("rnd%0d_%02h", k, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/midi_uart_tx.md
MIDI_UART_TX -- requirements
Module: midi_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI bit rate; derived constant DIV = CLK_HZ/BAUD (integer), DIV >= 2 required.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data  input  8  byte to transmit, held stable while valid && !ready.
REQ-006 SHALL have port valid  input  1  data presented.
REQ-007 SHALL have port ready  output  1  block can accept; transfer occurs on a cycle with valid && ready.
REQ-008 SHALL have port tx  output  1  serial MIDI line, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is on the line.

Function
REQ-010 SHALL use states IDLE, START, DATA, STOP; ready = 1 only in IDLE; busy = 1 in START, DATA and STOP.
REQ-011 SHALL, on transfer in IDLE, latch data and enter START the next cycle; tx goes low in that cycle (latency 1).
REQ-012 SHALL hold each bit on tx for exactly DIV cycles, counted by a baud counter reloaded to DIV-1 on frame start.
REQ-013 SHALL send frame 8N1: start bit 0, data[0]..data[7] LSB first, stop bit 1; START->DATA->STOP->IDLE on each baud terminal count.
REQ-014 SHALL count data bits with a 3-bit counter; DATA->STOP when count wraps from 7 with terminal count.
REQ-015 SHALL make the frame 10*DIV cycles; IDLE for at least 1 cycle between frames, so minimum byte period is 10*DIV+1 cycles.
REQ-016 SHALL ignore valid when not in IDLE; no byte lost or duplicated; valid dropping while ready=0 is legal and has no effect.
REQ-017 SHALL register tx directly from a flop (glitch-free output).

Reset
REQ-018 SHALL, when rst = 0, asynchronously force tx = 1, ready = 0, busy = 0, state IDLE, counters 0, running-status register cleared.
REQ-019 SHALL present ready = 1 on the first clock edge after rst deasserts.
REQ-020 SHALL abort any frame in progress on reset; tx returns high immediately; no partial frame resumes.

Configuration
REQ-021 SHALL implement running-status suppression only when macro MIDI_TX_RUNNING_STATUS_EN is defined.
REQ-022 With MIDI_TX_RUNNING_STATUS_EN: channel status byte 0x80-0xEF equal to last transmitted status SHALL be accepted and dropped (no frame, stays IDLE, ready remains 1); a different one is sent and stored.
REQ-023 With MIDI_TX_RUNNING_STATUS_EN: bytes 0xF0-0xF7 SHALL be sent and clear the stored status; 0xF8-0xFF (real-time) and data bytes 0x00-0x7F SHALL be sent and leave it unchanged.
REQ-024 Without MIDI_TX_RUNNING_STATUS_EN: every accepted byte SHALL be transmitted; no status register exists.

Structure
REQ-025 SHALL take MIDI_BAUD (31250), state enum typedef and status-range constants (0x80, 0xF0, 0xF8) from shared package midi_pkg.
REQ-026 SHALL instantiate one sub-module midi_baud_gen (param DIV; inputs clk, rst, restart; output one-cycle tick every DIV cycles, restart reloads).

Verification (CLK_HZ=1000000, BAUD=31250, DIV=32)
REQ-027 Send 0x90 after reset -> tx low 32 cycles, then 0,0,0,0,1,0,0,1 each 32 cycles, stop high 32; ready back after 320 cycles.
REQ-028 Hold valid high with 0x3C,0x7F back-to-back -> two complete frames, exactly 1 IDLE cycle between, both bytes correct.
REQ-029 Assert rst low at cycle 150 of a frame -> tx = 1 same cycle, ready = 1 first edge after release, no residual bits.
REQ-030 Macro defined: send 0x90,0x3C,0x7F,0x90,0x40,0x00 -> five frames on line, second 0x90 dropped without frame.
REQ-031 Macro defined: send 0x90, 0xF8, 0x90 -> all three transmitted? no: 0x90, 0xF8 sent, second 0x90 dropped; send 0xF0 then 0x90 -> both sent.
REQ-032 Macro undefined: repeat 0x90,0x90 -> two full frames transmitted.
